lsu_rmw: RTL

- Load/store unit that sits directly upstream of the core's byte-addressed, word-wide data RAM. The RAM reads combinationally, writes on the clock edge, and always writes a full 32-bit word.
- Converts core LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned RAM accesses.
- Sub-word stores are done as read-modify-write; load data is sign/zero extended.
- Misaligned, illegal or out-of-range accesses are flagged without touching the RAM.

---
 rtl/lsu_rmw.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-wide, combinational-read data RAM.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module lsu_rmw #(
  parameter int unsigned DATA_SIZE = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] ram_a_o,
  output logic        ram_we_o,
  output logic [31:0] ram_wd_o,
  input  logic [31:0] ram_rd_i
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = XLEN + 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              illegal_c, misalign_c, oor_c, err_c;
  logic [AW-1:0]     last_byte_c;

  // Merge the store operand into the word read from RAM (little-endian lanes).
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B: begin
        case (lane)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request decode, evaluated on the incoming (not yet registered) request.
  always_comb begin
    illegal_c = 1'b1;
    case (req_funct3_i)
      F3_B, F3_H, F3_W: illegal_c = 1'b0;
      F3_BU, F3_HU:     illegal_c = req_we_i;
      default:          illegal_c = 1'b1;
    endcase
    misalign_c = 1'b0;
    if ((req_funct3_i == F3_H) || (req_funct3_i == F3_HU))
      misalign_c = req_addr_i[0];
    else if (req_funct3_i == F3_W)
      misalign_c = (req_addr_i[1:0] != 2'b00);
    last_byte_c = {1'b0, req_addr_i[31:2], 2'b00} + AW'(3);
    oor_c       = (last_byte_c >= AW'(DATA_SIZE));
    err_c       = illegal_c | misalign_c | oor_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode; response fields change only on entry to RESP.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wd_d         = wd_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    ram_we_o     = 1'b0;
    resp_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (err_c) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_we_i && (req_funct3_i == F3_W)) begin
            wd_d    = req_wdata_i;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (we_q) begin
          wd_d    = store_merge(ram_rd_i, f3_q, addr_q[1:0], wdata_q);
          state_d = ST_WR;
        end else begin
          rdata_d = load_extract(ram_rd_i, f3_q, addr_q[1:0]);
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        ram_we_o = 1'b1;
        rdata_d  = '0;
        err_d    = 1'b0;
        state_d  = ST_RESP;
      end
      default: begin
        resp_valid_o = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  assign ram_a_o      = {addr_q[31:2], 2'b00};
  assign ram_wd_o     = wd_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule
